// File: rtl/fault_map_receiver.sv
// Receives per-column diagnostic beats into an N x N faulty-PE map, merges the
// whole-row/whole-column flags, and streams the merged map row by row to eNVM.
module fault_map_receiver #(
   parameter int SYSTOLIC_SIZE = 8,
   parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_en,
   input  logic                    diag_valid,
   input  logic [ADDR_WIDTH-1:0]   counter,
   input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
   input  logic                    column_fault_detection,
   input  logic                    row_fault_detection,
   output logic                    envm_wr_en,
   input  logic                    envm_ready,
   output logic [ADDR_WIDTH-1:0]   envm_row_addr,
   output logic [SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
   output logic [2*ADDR_WIDTH:0]   fault_count,
   output logic                    map_done,
   output logic                    protocol_error
);

   localparam int N  = SYSTOLIC_SIZE;
   localparam int CW = 2*ADDR_WIDTH+1;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N-1);

   typedef enum logic [2:0] {IDLE, COLLECT, MERGE, SEND, DONE} state_t;

   state_t state, state_next;

   logic [N-1:0]          fault_map  [N];
   logic [N-1:0]          merged_map [N];
   logic [N-1:0]          col_flag;
   logic [N-1:0]          row_flag;
   logic [ADDR_WIDTH-1:0] exp_idx;
   logic [ADDR_WIDTH-1:0] row_ptr;
   logic [CW-1:0]         merged_count;
   logic                  beat_ok;
   logic                  beat_bad;
   logic                  row_accept;

   // start_en wins over any beat or handshake in the same cycle
   assign beat_ok    = (state == COLLECT) && diag_valid && !start_en && (counter == exp_idx);
   assign beat_bad   = (state == COLLECT) && diag_valid && !start_en && (counter != exp_idx);
   assign row_accept = (state == SEND) && envm_ready && !start_en;

   always_comb begin
      merged_count = '0;
      for (int r = 0; r < N; r++) begin
         merged_map[r] = fault_map[r] | col_flag | {N{row_flag[r]}};
         for (int c = 0; c < N; c++) begin
            merged_count = merged_count + CW'(merged_map[r][c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (start_en) begin
         state_next = COLLECT;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            COLLECT: begin
               if (beat_bad)                        state_next = IDLE;
               else if (beat_ok && counter == LAST) state_next = MERGE;
            end
            MERGE:   state_next = SEND;
            SEND:    if (row_accept && row_ptr == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start_en) begin
         for (int r = 0; r < N; r++) fault_map[r] <= '0;
         col_flag       <= '0;
         row_flag       <= '0;
         exp_idx        <= '0;
         row_ptr        <= '0;
         fault_count    <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (beat_ok) begin
            for (int r = 0; r < N; r++) fault_map[r][counter] <= single_pe_detection[r];
            col_flag[counter] <= column_fault_detection;
            row_flag[counter] <= row_fault_detection;
            exp_idx           <= exp_idx + 1'b1;
         end
         if (beat_bad) protocol_error <= 1'b1;
         if (state == MERGE) begin
            for (int r = 0; r < N; r++) fault_map[r] <= merged_map[r];
            fault_count <= merged_count;
            row_ptr     <= '0;
         end
         if (row_accept) row_ptr <= row_ptr + 1'b1;
      end
   end

   assign envm_wr_en                = (state == SEND);
   assign envm_row_addr             = row_ptr;
   assign envm_faulty_patterns_flat = fault_map[row_ptr];
   assign map_done                  = (state == DONE);

endmodule

// File: tb/tb_fault_map_receiver.sv
// Directed bench for fault_map_receiver: sessions with hand-computed merged maps,
// backpressure, protocol error, abort and reset.
module tb_fault_map_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_en;
   logic       diag_valid;
   logic [2:0] counter;
   logic [7:0] single_pe_detection;
   logic       column_fault_detection;
   logic       row_fault_detection;
   logic       envm_wr_en;
   logic       envm_ready;
   logic [2:0] envm_row_addr;
   logic [7:0] envm_faulty_patterns_flat;
   logic [6:0] fault_count;
   logic       map_done;
   logic       protocol_error;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] beat_pe [8];
   logic [7:0] beat_col;
   logic [7:0] beat_row;
   logic [7:0] exp_rows [8];
   int         exp_count;
   int         done_ticks;
   int         wr_seen;

   fault_map_receiver #(.SYSTOLIC_SIZE(8)) dut (
      .clk(clk), .rst(rst), .start_en(start_en), .diag_valid(diag_valid),
      .counter(counter), .single_pe_detection(single_pe_detection),
      .column_fault_detection(column_fault_detection),
      .row_fault_detection(row_fault_detection), .envm_wr_en(envm_wr_en),
      .envm_ready(envm_ready), .envm_row_addr(envm_row_addr),
      .envm_faulty_patterns_flat(envm_faulty_patterns_flat),
      .fault_count(fault_count), .map_done(map_done), .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int c, input logic [7:0] pe, input logic colf, input logic rowf);
      diag_valid             = 1'b1;
      counter                = 3'(c);
      single_pe_detection    = pe;
      column_fault_detection = colf;
      row_fault_detection    = rowf;
      tick();
      diag_valid             = 1'b0;
   endtask

   task automatic startPulse();
      start_en = 1'b1;
      tick();
      start_en = 1'b0;
   endtask

   task automatic clearBeats();
      for (int c = 0; c < 8; c++) beat_pe[c] = 8'h00;
      beat_col = 8'h00;
      beat_row = 8'h00;
   endtask

   task automatic sendBeats();
      for (int c = 0; c < 8; c++) applyStimulus(c, beat_pe[c], beat_col[c], beat_row[c]);
   endtask

   // Starts right after the last beat's edge; ticks counts edges since that beat.
   task automatic runSend(input int stall_row, input int stall_len, output int ticks);
      int   stalls;
      int   wcount;
      logic seen_done;
      stalls = 0; wcount = 0; ticks = 1; seen_done = 1'b0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         if (map_done) begin
            seen_done = 1'b1;
         end else begin
            if (envm_wr_en) begin
               if (wcount == 0 && stalls == 0) checkOutput("fault_count", 64'(fault_count), 64'(exp_count));
               if (int'(envm_row_addr) == stall_row && stalls < stall_len) begin
                  envm_ready = 1'b0;
                  stalls++;
                  checkOutput("stall_addr", 64'(envm_row_addr), 64'(stall_row));
                  checkOutput("stall_data", 64'(envm_faulty_patterns_flat), 64'(exp_rows[stall_row]));
               end else begin
                  envm_ready = 1'b1;
                  checkOutput("wr_addr", 64'(envm_row_addr), 64'(wcount));
                  checkOutput("wr_data", 64'(envm_faulty_patterns_flat),
                              (wcount < 8) ? 64'(exp_rows[wcount]) : 64'hDEAD);
                  wcount++;
               end
            end
            tick();
            ticks++;
         end
      end
      if (!seen_done) ticks = -1;
      checkOutput("write_count", 64'(wcount), 64'd8);
      envm_ready = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_wr_en"}, 64'(envm_wr_en), 64'd0);
      checkOutput({tag, "_addr"},  64'(envm_row_addr), 64'd0);
      checkOutput({tag, "_data"},  64'(envm_faulty_patterns_flat), 64'd0);
      checkOutput({tag, "_count"}, 64'(fault_count), 64'd0);
      checkOutput({tag, "_done"},  64'(map_done), 64'd0);
      checkOutput({tag, "_err"},   64'(protocol_error), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start_en = 1'b0; diag_valid = 1'b0; counter = '0;
      single_pe_detection = '0; column_fault_detection = 1'b0;
      row_fault_detection = 1'b0; envm_ready = 1'b0;
      tick(); tick();
      checkResetOutputs("reset");
      rst = 1'b0;
      tick();

      // Fault-free map
      clearBeats();
      for (int r = 0; r < 8; r++) exp_rows[r] = 8'h00;
      exp_count = 0;
      startPulse();
      sendBeats();
      runSend(-1, 0, done_ticks);
      checkOutput("clean_done_latency", 64'(done_ticks), 64'd10);
      tick();
      checkOutput("done_one_cycle", 64'(map_done), 64'd0);

      // Single faulty PE(5,3)
      clearBeats();
      beat_pe[3] = 8'h20;
      for (int r = 0; r < 8; r++) exp_rows[r] = 8'h00;
      exp_rows[5] = 8'h08;
      exp_count = 1;
      startPulse();
      sendBeats();
      runSend(-1, 0, done_ticks);
      checkOutput("single_done_latency", 64'(done_ticks), 64'd10);
      tick();
      checkOutput("single_count_hold", 64'(fault_count), 64'd1);

      // Whole row 2 and whole column 6
      clearBeats();
      beat_row[2] = 1'b1;
      beat_col[6] = 1'b1;
      for (int r = 0; r < 8; r++) exp_rows[r] = 8'h40;
      exp_rows[2] = 8'hFF;
      exp_count = 15;
      startPulse();
      sendBeats();
      runSend(-1, 0, done_ticks);
      checkOutput("merge_done_latency", 64'(done_ticks), 64'd10);

      // Backpressure: 3 stall cycles at row 4
      clearBeats();
      beat_pe[3] = 8'h20;
      for (int r = 0; r < 8; r++) exp_rows[r] = 8'h00;
      exp_rows[5] = 8'h08;
      exp_count = 1;
      startPulse();
      sendBeats();
      runSend(4, 3, done_ticks);
      checkOutput("stall_done_latency", 64'(done_ticks), 64'd13);

      // Out-of-order beat
      startPulse();
      applyStimulus(0, 8'h01, 1'b0, 1'b0);
      applyStimulus(1, 8'h02, 1'b0, 1'b0);
      applyStimulus(3, 8'h04, 1'b0, 1'b0);
      checkOutput("proto_err_set", 64'(protocol_error), 64'd1);
      wr_seen = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c, 8'hFF, 1'b1, 1'b1);
         if (envm_wr_en) wr_seen++;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (envm_wr_en) wr_seen++;
      end
      checkOutput("proto_no_write", 64'(wr_seen), 64'd0);
      checkOutput("proto_err_sticky", 64'(protocol_error), 64'd1);
      startPulse();
      checkOutput("proto_err_clear", 64'(protocol_error), 64'd0);

      // Abort during SEND at row 3, then a fresh session
      clearBeats();
      beat_pe[0] = 8'hFF;
      sendBeats();
      envm_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("abort_pre_wr_en", 64'(envm_wr_en), 64'd1);
      checkOutput("abort_pre_addr", 64'(envm_row_addr), 64'd3);
      envm_ready = 1'b0;
      startPulse();
      checkOutput("abort_wr_en", 64'(envm_wr_en), 64'd0);
      checkOutput("abort_done", 64'(map_done), 64'd0);
      clearBeats();
      beat_row[2] = 1'b1;
      beat_col[6] = 1'b1;
      for (int r = 0; r < 8; r++) exp_rows[r] = 8'h40;
      exp_rows[2] = 8'hFF;
      exp_count = 15;
      sendBeats();
      runSend(-1, 0, done_ticks);
      checkOutput("abort_new_latency", 64'(done_ticks), 64'd10);

      // Reset mid-SEND
      clearBeats();
      beat_col[1] = 1'b1;
      startPulse();
      sendBeats();
      envm_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("rst_send_pre_addr", 64'(envm_row_addr), 64'd2);
      checkOutput("rst_send_pre_count", 64'(fault_count), 64'd8);
      envm_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkResetOutputs("rst_send");

      // Reset mid-COLLECT
      startPulse();
      for (int c = 0; c < 4; c++) applyStimulus(c, 8'hAA, 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkResetOutputs("rst_collect");
      for (int c = 4; c < 8; c++) applyStimulus(c, 8'hAA, 1'b1, 1'b1);
      tick(); tick();
      checkOutput("rst_collect_no_write", 64'(envm_wr_en), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
